// File: rtl/uart_tx_parity.sv
// UART transmitter: start, 8 data bits LSB first, parity, stop.
// A one-entry holding register lets the next byte queue up so frames can run back to back.
module uart_tx_parity #(
    parameter int CLKS_PER_BIT = 8,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       data_line,
    output logic       busy,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift, shift_next;
    logic [7:0]    hold, hold_next;
    logic          hold_full, hold_full_next;
    logic          done_next;
    logic          accept;
    logic          bit_end;

    assign accept   = tx_valid && !hold_full;
    assign bit_end  = (cnt == CNT_LAST);
    assign tx_ready = !hold_full;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            shift     <= shift_next;
            hold      <= hold_next;
            hold_full <= hold_full_next;
            done      <= done_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        bit_idx_next   = bit_idx;
        shift_next     = shift;
        hold_next      = hold;
        hold_full_next = hold_full;
        done_next      = 1'b0;
        data_line      = 1'b1;

        case (state)
            IDLE: begin
                data_line    = 1'b1;
                cnt_next     = '0;
                bit_idx_next = '0;
                // A byte left in the holding register by an accept on the STOP exit edge starts here.
                if (hold_full) begin
                    shift_next     = hold;
                    hold_full_next = 1'b0;
                    state_next     = START;
                end else if (accept) begin
                    shift_next = tx_data;
                    state_next = START;
                end
            end
            START: begin
                data_line = 1'b0;
                if (bit_end) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DATA: begin
                data_line = shift[bit_idx];
                if (bit_end) begin
                    cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        bit_idx_next = '0;
                        state_next   = PARITY;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            PARITY: begin
                data_line = (^shift) ^ PARITY_ODD;
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = STOP;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            STOP: begin
                data_line = 1'b1;
                if (bit_end) begin
                    cnt_next  = '0;
                    done_next = 1'b1;
                    if (hold_full) begin
                        shift_next     = hold;
                        hold_full_next = 1'b0;
                        state_next     = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                data_line    = 1'b1;
                cnt_next     = '0;
                bit_idx_next = '0;
                state_next   = IDLE;
            end
        endcase

        if (accept && (state != IDLE)) begin
            hold_next      = tx_data;
            hold_full_next = 1'b1;
        end
    end

endmodule
